// File: rtl/ram_port_controller_pkg.sv
// Shared types and defaults for the RAM port controller and its read timer.
package ram_port_controller_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RD_TIMEOUT = 15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  // Counter must be able to hold RD_TIMEOUT itself so it can saturate there.
  function automatic int timer_width(input int rd_timeout);
    return $clog2(rd_timeout + 1);
  endfunction

endpackage

// File: rtl/ram_rd_timer.sv
// Read-wait timer: counts enabled cycles from a clear, saturates, and flags
// expiry while the count sits at RD_TIMEOUT-1.
module ram_rd_timer
  import ram_port_controller_pkg::*;
#(
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = timer_width(RD_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [TW-1:0] SAT  = TW'(RD_TIMEOUT);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/ram_port_controller.sv
// Valid/ready front-end for the single-port RAM: sequences writes and reads
// onto the RAM pins and returns read data (or a timeout error) as a response.
module ram_port_controller
  import ram_port_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_en,
  output logic                  ram_wr_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_out_en,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_wr_rd_q, ram_wr_rd_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expire;

  ram_rd_timer #(
    .RD_TIMEOUT(RD_TIMEOUT)
  ) u_rd_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ram_en_d      = ram_en_q;
    ram_wr_rd_d   = ram_wr_rd_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ram_addr_d    = req_addr;
          ram_data_in_d = req_wdata;
          ram_wr_rd_d   = req_wr;
          ram_en_d      = 1'b1;
          if (req_wr) begin
            state_d = S_WRITE;
          end else begin
            timer_clr = 1'b1;
            state_d   = S_RD_WAIT;
          end
        end
      end

      S_WRITE: begin
        ram_en_d    = 1'b0;
        ram_wr_rd_d = 1'b0;
        state_d     = S_IDLE;
      end

      S_RD_WAIT: begin
        // out_en is tested first so a late but valid read beats the timeout.
        if (ram_out_en) begin
          rsp_rdata_d = ram_data_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          ram_en_d    = 1'b0;
          state_d     = S_RESP;
        end else if (timer_expire) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          ram_en_d    = 1'b0;
          state_d     = S_RESP;
        end else begin
          timer_en = 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ram_en_q      <= 1'b0;
      ram_wr_rd_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ram_en_q      <= ram_en_d;
      ram_wr_rd_q   <= ram_wr_rd_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // State already sits at IDLE during reset, so ready is masked by rst itself.
  assign req_ready   = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);

  assign ram_en      = ram_en_q;
  assign ram_wr_rd   = ram_wr_rd_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_ram_port_controller.sv
// Self-checking bench for ram_port_controller with a behavioural single-port RAM.
module tb_ram_port_controller;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ram_en;
  logic          ram_wr_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          ram_out_en;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // 0 = RAM model drives out_en/data, 1 = out_en tied low, 2 = bench drives them
  int            ram_mode = 0;
  logic          man_out_en = 1'b0;
  logic [DW-1:0] man_data   = '0;

  logic [DW-1:0] model_mem [8];
  logic          model_out_en = 1'b0;
  logic [DW-1:0] model_dout   = '0;

  always @(posedge clk) begin
    if (ram_en && ram_wr_rd) model_mem[ram_addr] <= ram_data_in;
    if (ram_en && !ram_wr_rd) model_dout <= model_mem[ram_addr];
    model_out_en <= ram_en && !ram_wr_rd;
  end

  assign ram_out_en   = (ram_mode == 0) ? model_out_en :
                        (ram_mode == 2) ? man_out_en   : 1'b0;
  assign ram_data_out = (ram_mode == 2) ? man_data : model_dout;

  ram_port_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_en       (ram_en),
    .ram_wr_rd    (ram_wr_rd),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .ram_out_en   (ram_out_en),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait_expired", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) check("rsp_valid_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send_req(1'b1, a, d);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] rd,
                         output logic err, output int cyc);
    send_req(1'b0, a, '0);
    wait_rsp(cyc);
    rd  = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
  endtask

  initial begin
    vec_t          vecs [10];
    logic [DW-1:0] mirror [8];
    logic [DW-1:0] rd;
    logic          err;
    int            cyc;
    int            seen_valid;
    int            seen_en;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    vecs[0] = '{1'b1, 3'd0, 8'h11, 8'h00};
    vecs[1] = '{1'b1, 3'd7, 8'hEE, 8'h00};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 8'h11};
    vecs[3] = '{1'b0, 3'd7, 8'h00, 8'hEE};
    vecs[4] = '{1'b1, 3'd0, 8'h22, 8'h00};
    vecs[5] = '{1'b0, 3'd0, 8'h00, 8'h22};
    vecs[6] = '{1'b1, 3'd1, 8'hFF, 8'h00};
    vecs[7] = '{1'b0, 3'd1, 8'h00, 8'hFF};
    vecs[8] = '{1'b1, 3'd1, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 3'd1, 8'h00, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ram_en",    32'(ram_en),    32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    rst = 1'b0;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Test 1: write 0xA5 @ 3, then read it back
    send_req(1'b1, 3'd3, 8'hA5);
    check("t1_wr_ram_en",    32'(ram_en),      32'd1);
    check("t1_wr_wr_rd",     32'(ram_wr_rd),   32'd1);
    check("t1_wr_addr",      32'(ram_addr),    32'd3);
    check("t1_wr_data",      32'(ram_data_in), 32'hA5);
    check("t1_wr_req_ready", 32'(req_ready),   32'd0);
    check("t1_wr_busy",      32'(busy),        32'd1);
    @(negedge clk);
    check("t1_wr_en_drop",    32'(ram_en),    32'd0);
    check("t1_wr_wrrd_drop",  32'(ram_wr_rd), 32'd0);
    check("t1_wr_ready_back", 32'(req_ready), 32'd1);
    send_req(1'b0, 3'd3, 8'h00);
    check("t1_rd_ram_en", 32'(ram_en),    32'd1);
    check("t1_rd_wr_rd",  32'(ram_wr_rd), 32'd0);
    check("t1_rd_addr",   32'(ram_addr),  32'd3);
    wait_rsp(cyc);
    check("t1_rd_latency", 32'(cyc),       32'd2);
    check("t1_rd_data",    32'(rsp_rdata), 32'hA5);
    check("t1_rd_err",     32'(rsp_err),   32'd0);
    check("t1_rsp_en_low", 32'(ram_en),    32'd0);
    @(negedge clk);
    check("t1_rsp_done", 32'(rsp_valid), 32'd0);
    check("t1_idle",     32'(busy),      32'd0);

    // Table-driven write/read vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        send_req(1'b1, vecs[i].addr, vecs[i].wdata);
        check($sformatf("vec%0d_wr_strobe", i), {30'd0, ram_en, ram_wr_rd}, 32'd3);
        check($sformatf("vec%0d_wr_addr", i),   32'(ram_addr),    32'(vecs[i].addr));
        check($sformatf("vec%0d_wr_data", i),   32'(ram_data_in), 32'(vecs[i].wdata));
        @(negedge clk);
        check($sformatf("vec%0d_wr_end", i), 32'(ram_en), 32'd0);
      end else begin
        do_read(vecs[i].addr, rd, err, cyc);
        check($sformatf("vec%0d_rd_data", i), 32'(rd),  32'(vecs[i].exp_rdata));
        check($sformatf("vec%0d_rd_err", i),  32'(err), 32'd0);
      end
    end

    // Test 2: random write/read sweep against a mirror
    for (int i = 0; i < 8; i++) mirror[i] = 8'h00;
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(0, 7));
      d = DW'($urandom);
      do_write(a, d);
      mirror[a] = d;
      do_read(a, rd, err, cyc);
      check($sformatf("t2_sweep%0d_data", i), 32'(rd),  32'(mirror[a]));
      check($sformatf("t2_sweep%0d_err", i),  32'(err), 32'd0);
    end

    // Test 3: timeout with out_en tied low
    ram_mode = 1;
    send_req(1'b0, 3'd5, 8'h00);
    wait_rsp(cyc);
    // acceptance edge plus RD_TIMEOUT further edges
    check("t3_timeout_latency", 32'(cyc + 1),  32'(TO + 1));
    check("t3_err",             32'(rsp_err),   32'd1);
    check("t3_rdata_zero",      32'(rsp_rdata), 32'h00);
    check("t3_ram_en_low",      32'(ram_en),    32'd0);
    @(negedge clk);
    check("t3_err_cleared", 32'(rsp_err),   32'd0);
    check("t3_done",        32'(rsp_valid), 32'd0);
    ram_mode = 0;

    // Test 4: response backpressure for 7 cycles
    do_write(3'd6, 8'h3C);
    rsp_ready = 1'b0;
    send_req(1'b0, 3'd6, 8'h00);
    wait_rsp(cyc);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 3'd6;
    req_wdata = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t4_hold%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("t4_hold%0d_rdata", i), 32'(rsp_rdata), 32'h3C);
      check($sformatf("t4_hold%0d_ready", i), 32'(req_ready), 32'd0);
      check($sformatf("t4_hold%0d_en", i),    32'(ram_en),    32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", 32'(rsp_valid), 32'd0);
    check("t4_release_ready", 32'(req_ready), 32'd1);
    do_read(3'd6, rd, err, cyc);
    check("t4_no_stray_write", 32'(rd), 32'h3C);

    // Test 6: out_en arrives in the same cycle the timer expires
    ram_mode = 2;
    send_req(1'b0, 3'd2, 8'h00);
    repeat (TO - 1) @(negedge clk);
    check("t6_not_yet_expired", 32'(rsp_valid), 32'd0);
    man_out_en = 1'b1;
    man_data   = 8'h5A;
    @(negedge clk);
    man_out_en = 1'b0;
    check("t6_valid", 32'(rsp_valid), 32'd1);
    check("t6_err",   32'(rsp_err),   32'd0);
    check("t6_rdata", 32'(rsp_rdata), 32'h5A);
    @(negedge clk);
    ram_mode = 0;

    // Test 5: reset in the middle of a read
    ram_mode = 1;
    send_req(1'b0, 3'd4, 8'h00);
    repeat (3) @(negedge clk);
    check("t5_pre_busy",   32'(busy),   32'd1);
    check("t5_pre_ram_en", 32'(ram_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_ram_en",    32'(ram_en),    32'd0);
    check("t5_async_busy",      32'(busy),      32'd0);
    check("t5_async_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_release_ready", 32'(req_ready), 32'd1);
    seen_valid = 0;
    seen_en    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
      if (ram_en) seen_en++;
    end
    check("t5_no_response", 32'(seen_valid), 32'd0);
    check("t5_no_ram_en",   32'(seen_en),    32'd0);
    ram_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
